// File: rtl/board_display_pkg.sv
// Shared types and defaults for the board display path: colour type,
// 640x480 VGA timing defaults, fixed colours and width helpers.
package board_display_pkg;

  typedef logic [2:0] color_t;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam color_t DEF_BORDER_COLOR = 3'b111;
  localparam color_t COLOR_BLACK      = 3'b000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Address width that stays legal for a single-entry dimension.
  function automatic int addr_w(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 raster counters with sync / visible decode and the vblank-start
// strobe that paces every per-frame event in the display engine.
module vga_timing_gen
  import board_display_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       in_display,
  output logic       vbs
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = !((x_q >= HS_BEG) && (x_q < HS_END));
  assign vsync      = !((y_q >= VS_BEG) && (y_q < VS_END));
  assign in_display = (x_q < H_VIS_C) && (y_q < V_VIS_C);
  assign vbs        = (x_q == '0) && (y_q == V_VIS_C);

endmodule

// File: rtl/board_display_engine.sv
// Scans a COLS x ROWS double-buffered cell board onto VGA with a 2-cycle
// aligned pipeline. Define BOARD_GRID_LINES_EN to draw black cell grid lines.
module board_display_engine
  import board_display_pkg::*;
#(
  parameter int     COLS         = 10,
  parameter int     ROWS         = 20,
  parameter int     CELL_PX      = 16,
  parameter int     ORIGIN_X     = 240,
  parameter int     ORIGIN_Y     = 80,
  parameter int     H_VIS        = DEF_H_VIS,
  parameter int     H_FP         = DEF_H_FP,
  parameter int     H_SYNC       = DEF_H_SYNC,
  parameter int     H_BP         = DEF_H_BP,
  parameter int     V_VIS        = DEF_V_VIS,
  parameter int     V_FP         = DEF_V_FP,
  parameter int     V_SYNC       = DEF_V_SYNC,
  parameter int     V_BP         = DEF_V_BP,
  parameter int     ACT_W        = 4,
  parameter int     TICK_FRAMES  = 30,
  parameter int     FC_W         = 11,
  parameter color_t BORDER_COLOR = DEF_BORDER_COLOR
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ACT_W-1:0]            actions,
  output logic                        cell_rd_bank,
  output logic [addr_w(COLS)-1:0]     cell_rd_x,
  output logic [addr_w(ROWS)-1:0]     cell_rd_y,
  input  logic [2:0]                  cell_rd_data,
  input  logic                        commit,
  output logic                        commit_ack,
  output logic                        back_bank,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        in_display,
  output logic [2:0]                  vga_rgb,
  output logic [9:0]                  count_x,
  output logic [9:0]                  count_y,
  output logic [FC_W-1:0]             frame_count,
  output logic                        game_tick,
  output logic                        act_valid,
  output logic [ACT_W-1:0]            act_pulse
);

  localparam int XW      = addr_w(COLS);
  localparam int YW      = addr_w(ROWS);
  localparam int TW      = addr_w(TICK_FRAMES);
  localparam int CELL_SH = clog2(CELL_PX);

  localparam logic [9:0]    PF_X0     = 10'(ORIGIN_X);
  localparam logic [9:0]    PF_X1     = 10'(ORIGIN_X + COLS * CELL_PX);
  localparam logic [9:0]    PF_Y0     = 10'(ORIGIN_Y);
  localparam logic [9:0]    PF_Y1     = 10'(ORIGIN_Y + ROWS * CELL_PX);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_FRAMES - 1);

  if (CELL_PX < 1 || (CELL_PX & (CELL_PX - 1)) != 0) begin : g_bad_cell_px
    $error("CELL_PX must be a power of two");
  end
  if (ORIGIN_X + COLS * CELL_PX > H_VIS) begin : g_bad_width
    $error("playfield exceeds the visible width");
  end
  if (ORIGIN_Y + ROWS * CELL_PX > V_VIS) begin : g_bad_height
    $error("playfield exceeds the visible height");
  end
  if (H_VIS + H_FP + H_SYNC + H_BP > 1024 || V_VIS + V_FP + V_SYNC + V_BP > 1024) begin : g_bad_timing
    $error("raster totals must fit the 10-bit counters");
  end

  logic [9:0] x_p0, y_p0;
  logic       hs_p0, vs_p0, vld_p0, vbs_p0;

  vga_timing_gen #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clock      (clock),
    .reset      (reset),
    .x          (x_p0),
    .y          (y_p0),
    .hsync      (hs_p0),
    .vsync      (vs_p0),
    .in_display (vld_p0),
    .vbs        (vbs_p0)
  );

  // Stage 0 -> 1: playfield decode and registered cell address
  logic [9:0]    dx_p0, dy_p0;
  logic          pf_p0;
  logic [9:0]    x_p1_q, x_p1_d, y_p1_q, y_p1_d;
  logic          hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic          vld_p1_q, vld_p1_d, pf_p1_q, pf_p1_d;
  logic [XW-1:0] cell_x_p1_q, cell_x_p1_d;
  logic [YW-1:0] cell_y_p1_q, cell_y_p1_d;
`ifdef BOARD_GRID_LINES_EN
  localparam logic [9:0] CELL_MASK = 10'(CELL_PX - 1);
  logic grid_p1_q, grid_p1_d, grid_p2_q, grid_p2_d;
`endif

  always_comb begin
    dx_p0       = x_p0 - PF_X0;
    dy_p0       = y_p0 - PF_Y0;
    pf_p0       = (x_p0 >= PF_X0) && (x_p0 < PF_X1) && (y_p0 >= PF_Y0) && (y_p0 < PF_Y1);
    x_p1_d      = x_p0;
    y_p1_d      = y_p0;
    hs_p1_d     = hs_p0;
    vs_p1_d     = vs_p0;
    vld_p1_d    = vld_p0;
    pf_p1_d     = pf_p0;
    cell_x_p1_d = pf_p0 ? XW'(dx_p0 >> CELL_SH) : '0;
    cell_y_p1_d = pf_p0 ? YW'(dy_p0 >> CELL_SH) : '0;
`ifdef BOARD_GRID_LINES_EN
    grid_p1_d   = pf_p0 && (((dx_p0 & CELL_MASK) == '0) || ((dy_p0 & CELL_MASK) == '0));
`endif
  end

  // Stage 1 -> 2: realign control with the RAM read data
  logic [9:0] x_p2_q, x_p2_d, y_p2_q, y_p2_d;
  logic       hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
  logic       vld_p2_q, vld_p2_d, pf_p2_q, pf_p2_d;

  always_comb begin
    x_p2_d    = x_p1_q;
    y_p2_d    = y_p1_q;
    hs_p2_d   = hs_p1_q;
    vs_p2_d   = vs_p1_q;
    vld_p2_d  = vld_p1_q;
    pf_p2_d   = pf_p1_q;
`ifdef BOARD_GRID_LINES_EN
    grid_p2_d = grid_p1_q;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_p1_q      <= '0;
      y_p1_q      <= '0;
      hs_p1_q     <= 1'b1;
      vs_p1_q     <= 1'b1;
      vld_p1_q    <= 1'b0;
      pf_p1_q     <= 1'b0;
      cell_x_p1_q <= '0;
      cell_y_p1_q <= '0;
      x_p2_q      <= '0;
      y_p2_q      <= '0;
      hs_p2_q     <= 1'b1;
      vs_p2_q     <= 1'b1;
      vld_p2_q    <= 1'b0;
      pf_p2_q     <= 1'b0;
`ifdef BOARD_GRID_LINES_EN
      grid_p1_q   <= 1'b0;
      grid_p2_q   <= 1'b0;
`endif
    end else begin
      x_p1_q      <= x_p1_d;
      y_p1_q      <= y_p1_d;
      hs_p1_q     <= hs_p1_d;
      vs_p1_q     <= vs_p1_d;
      vld_p1_q    <= vld_p1_d;
      pf_p1_q     <= pf_p1_d;
      cell_x_p1_q <= cell_x_p1_d;
      cell_y_p1_q <= cell_y_p1_d;
      x_p2_q      <= x_p2_d;
      y_p2_q      <= y_p2_d;
      hs_p2_q     <= hs_p2_d;
      vs_p2_q     <= vs_p2_d;
      vld_p2_q    <= vld_p2_d;
      pf_p2_q     <= pf_p2_d;
`ifdef BOARD_GRID_LINES_EN
      grid_p1_q   <= grid_p1_d;
      grid_p2_q   <= grid_p2_d;
`endif
    end
  end

  // Stage 2: colour select; cell_rd_data arrives this cycle
  color_t rgb_p2;

  always_comb begin
    rgb_p2 = COLOR_BLACK;
    if (vld_p2_q) begin
      if (pf_p2_q) begin
`ifdef BOARD_GRID_LINES_EN
        rgb_p2 = grid_p2_q ? COLOR_BLACK : cell_rd_data;
`else
        rgb_p2 = cell_rd_data;
`endif
      end else begin
        rgb_p2 = BORDER_COLOR;
      end
    end
  end

  // Per-frame control, all keyed off the stage-0 vblank-start strobe
  logic             front_q, front_d;
  logic             commit_ack_q, commit_ack_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             game_tick_q, game_tick_d;
  logic             act_valid_q, act_valid_d;
  logic [ACT_W-1:0] act_pulse_q, act_pulse_d;
  logic [ACT_W-1:0] capture_q, capture_d;

  always_comb begin
    front_d      = front_q;
    commit_ack_d = 1'b0;
    fc_d         = fc_q;
    tick_cnt_d   = tick_cnt_q;
    game_tick_d  = 1'b0;
    act_valid_d  = 1'b0;
    act_pulse_d  = act_pulse_q;
    capture_d    = capture_q | actions;
    if (vbs_p0) begin
      fc_d = fc_q + FC_W'(1);
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d  = '0;
        game_tick_d = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
      act_valid_d = 1'b1;
      act_pulse_d = capture_q | actions;
      capture_d   = '0;
      if (commit) begin
        front_d      = ~front_q;
        commit_ack_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      front_q      <= 1'b0;
      commit_ack_q <= 1'b0;
      fc_q         <= '0;
      tick_cnt_q   <= '0;
      game_tick_q  <= 1'b0;
      act_valid_q  <= 1'b0;
      act_pulse_q  <= '0;
      capture_q    <= '0;
    end else begin
      front_q      <= front_d;
      commit_ack_q <= commit_ack_d;
      fc_q         <= fc_d;
      tick_cnt_q   <= tick_cnt_d;
      game_tick_q  <= game_tick_d;
      act_valid_q  <= act_valid_d;
      act_pulse_q  <= act_pulse_d;
      capture_q    <= capture_d;
    end
  end

  assign cell_rd_bank = front_q;
  assign back_bank    = ~front_q;
  assign cell_rd_x    = cell_x_p1_q;
  assign cell_rd_y    = cell_y_p1_q;
  assign commit_ack   = commit_ack_q;
  assign hsync        = hs_p2_q;
  assign vsync        = vs_p2_q;
  assign in_display   = vld_p2_q;
  assign vga_rgb      = rgb_p2;
  assign count_x      = x_p2_q;
  assign count_y      = y_p2_q;
  assign frame_count  = fc_q;
  assign game_tick    = game_tick_q;
  assign act_valid    = act_valid_q;
  assign act_pulse    = act_pulse_q;

endmodule

// File: doc/board_display_engine.md
Name: board_display_engine

Overview:
- Parametrised successor to the fixed 10x20 Tetris display path.
- Generates VGA timing and scans a COLS x ROWS cell board held in external dual-bank memory.
- Scales each cell to CELL_PX pixels, draws a border, and double-buffers the board with swaps only in vblank.
- Provides frame count, periodic game tick and per-frame latched player actions to the game logic.

Parameters:
- COLS, 10, board width in cells
- ROWS, 20, board height in cells
- CELL_PX, 16, cell edge in pixels; power of two
- ORIGIN_X, 240, leftmost playfield pixel
- ORIGIN_Y, 80, topmost playfield pixel
- H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in clocks
- V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines
- ACT_W, 4, action input width
- TICK_FRAMES, 30, frames per game_tick
- FC_W, 11, frame_count width
- BORDER_COLOR, 3'b111, colour outside the playfield but inside the display

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- actions  in  ACT_W  raw player inputs, level
- cell_rd_bank  out  1  bank being displayed (front)
- cell_rd_x  out  clog2(COLS)  column address
- cell_rd_y  out  clog2(ROWS)  row address
- cell_rd_data  in  3  cell colour; 1-cycle read latency
- commit  in  1  game logic requests a bank swap; held until commit_ack
- commit_ack  out  1  one-cycle pulse: swap performed
- back_bank  out  1  bank the game logic may write (~front)
- hsync, vsync  out  1  active-low syncs
- in_display  out  1  visible-area flag
- vga_rgb  out  3  {b,g,r} pixel
- count_x, count_y  out  10  pixel coordinates aligned with vga_rgb
- frame_count  out  FC_W  frames completed
- game_tick  out  1  one-cycle pulse every TICK_FRAMES frames
- act_valid  out  1  one-cycle pulse at vblank start
- act_pulse  out  ACT_W  actions captured during the last frame

Behaviour:
- Reset values:
  - counters and frame_count 0
  - hsync and vsync 1
  - in_display 0, vga_rgb 0
  - front bank 0, back_bank 1
  - commit_ack, game_tick, act_valid and act_pulse 0
  - capture register 0, tick counter 0
- Stage-0 counters:
  - x runs 0..H_TOT-1, where H_TOT is the sum of the four horizontal timing parameters; wraps to 0.
  - y increments on x wrap, runs 0..V_TOT-1 with V_TOT defined the same way, and wraps.
- Sync and display decode:
  - hsync is low for x in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC).
  - vsync is decoded the same way on y.
  - in_display = x<H_VIS && y<V_VIS.
- Pipeline: the cell address is registered at stage 1 and the RAM returns data at stage 2. All outputs (syncs, in_display, counts, rgb) are delayed 2 cycles so they are mutually aligned. Fixed latency is 2.
- Playfield: x in [ORIGIN_X, ORIGIN_X+COLS*CELL_PX) and y in [ORIGIN_Y, ORIGIN_Y+ROWS*CELL_PX).
  - cell_rd_x = (x-ORIGIN_X)>>log2(CELL_PX); cell_rd_y likewise.
  - Outside the playfield the address holds 0.
- Colour select:
  - playfield: cell_rd_data
  - visible non-playfield: BORDER_COLOR
  - blanking: 0
- Vblank start (VBS) is the stage-0 cycle with x==0 and y==V_VIS. At VBS:
  - frame_count increments, modulo 2^FC_W.
  - Tick counter: if it equals TICK_FRAMES-1, game_tick pulses and the counter clears; otherwise it increments.
  - act_valid pulses and act_pulse = capture | actions. Capture then clears; actions present on the VBS cycle are not carried over.
  - act_pulse is held until the next VBS.
  - If commit is high (including a commit first asserted on the VBS cycle itself): front bank toggles, commit_ack pulses, back_bank updates the same cycle.
- Outside VBS: capture |= actions every cycle.
- commit is only sampled at VBS, so there are never two swaps per frame. Commit deasserted before VBS is lost; the game logic must hold it.
- The bank only changes at VBS, so no tearing inside the visible area.
- Reset asserted mid-frame restores every reset value on the next edge. In-flight pipeline data is discarded (rgb 0).
- Elaboration error if CELL_PX is not a power of 2, or the playfield exceeds H_VIS/V_VIS.

Optional Feature:
- Macro: BOARD_GRID_LINES_EN.
- Defined: playfield pixels whose in-cell x offset or y offset is 0 are drawn 3'b000 (grid lines). The cell read still happens and latency is unchanged.
- Undefined: whole cells are drawn in cell_rd_data colour.

Decomposition:
- Package board_display_pkg:
  - colour typedef (3-bit)
  - default VGA 640x480 timing constants
  - BORDER_COLOR and black constants
  - clog2 helper
- Sub-module vga_timing_gen: stage-0 x/y counters, sync/in_display decode and the VBS strobe. The top handles the cell pipeline, colour mux, bank swap, tick and action capture.

Test Plan:
- Reset, run 2 frames:
  - hsync low exactly 96 clocks per 800-clock line.
  - vsync low 2 lines per 525-line frame.
  - frame_count = 2.
- Board model with cell (0,0)=3'b001 and (9,19)=3'b100:
  - pixel (240,80) -> rgb 001.
  - pixel (399,399) -> rgb 100.
  - pixel (239,80) -> 111.
  - pixel (700,10) -> 000.
  - All with 2-cycle alignment to count_x/count_y.
- actions[1] pulsed for 1 clock mid-frame -> at next VBS act_valid=1, act_pulse=4'b0010. The following VBS gives act_pulse=0.
- commit raised at line 100 -> commit_ack and bank toggle exactly at VBS, cell_rd_bank=1. commit held high for a further frame -> second toggle at the next VBS.
- TICK_FRAMES=3 -> game_tick on frames 3, 6, 9 only.
- Reset asserted at x=300,y=200 -> next cycle outputs equal reset values, front bank 0, capture cleared.
